// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, diff = (a - b - bin) mod 2^WIDTH, DIGIT bits per clock, LSB digit first.
// Latency: N = WIDTH/DIGIT edges from the accepting edge to done; one op every N+2 cycles.
// Backpressure: start is only accepted while ready=1; start in RUN/DONE is dropped (no queuing).
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset (aborts any op in flight)
//   start, a, b, bin  request + operands, sampled only on the accepting edge
//   ready             idle, will accept start
//   done              one-cycle pulse, results valid
//   diff, bout        difference and unsigned borrow-out (a < b + bin)
//   ovf, zero         two's-complement overflow, diff == 0
module serial_sub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;
   logic             r_bout;
   logic             r_ovf;
   logic             r_zero;
   logic             r_a_msb;
   logic             r_b_msb;
   logic [CW-1:0]    r_cnt;

   logic [DIGIT:0]   w_dig_ext;
   logic [DIGIT-1:0] w_dig;
   logic             w_borrow;
   logic             w_last;
   logic             w_load;
   logic             w_step;
   logic [WIDTH-1:0] w_diff_next;

   // One digit of the borrow chain: the extra top bit of the widened
   // subtraction is the borrow out of this digit.
   assign w_dig_ext = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]}
                    - {{DIGIT{1'b0}}, r_borrow};
   assign w_dig     = w_dig_ext[DIGIT-1:0];
   assign w_borrow  = w_dig_ext[DIGIT];

   // Result digits enter from the MSB side, so after N steps digit 0 has
   // reached the LSB position. Shift forms keep DIGIT == WIDTH legal.
   assign w_diff_next = (r_diff >> DIGIT) | (WIDTH'(w_dig) << (WIDTH - DIGIT));

   assign w_last = (r_cnt == CW'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      ready        = 1'b0;
      done         = 1'b0;
      w_load       = 1'b0;
      w_step       = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready = 1'b1;
            if (start) begin
               w_load       = 1'b1;
               w_next_state = S_RUN;
            end
         end
         S_RUN: begin
            w_step = 1'b1;
            if (w_last) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            done         = 1'b1;
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_bout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_cnt    <= '0;
      end else if (w_load) begin
         r_a      <= a;
         r_b      <= b;
         r_borrow <= bin;
         r_cnt    <= '0;
         // Operand MSBs are kept aside because the shift registers have
         // consumed them by the time the overflow flag is formed.
         r_a_msb  <= a[WIDTH-1];
         r_b_msb  <= b[WIDTH-1];
      end else if (w_step) begin
         r_a      <= r_a >> DIGIT;
         r_b      <= r_b >> DIGIT;
         r_borrow <= w_borrow;
         r_cnt    <= r_cnt + CW'(1);
         r_diff   <= w_diff_next;
         if (w_last) begin
            r_bout <= w_borrow;
            r_ovf  <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_diff_next[WIDTH-1]);
            r_zero <= (w_diff_next == '0);
         end
      end
   end

   assign diff = r_diff;
   assign bout = r_bout;
   assign ovf  = r_ovf;
   assign zero = r_zero;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub, one 8-bit/1-bit-digit instance
// plus four 16-bit instances (DIGIT 1, 2, 4, 16) driven with identical operands.
// Expected results are queued at start and compared when done pulses.
module tb_serial_sub;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      logic [15:0] diff;
      logic        bout;
      logic        ovf;
      logic        zero;
      int          c0;
   } exp_t;

   // ---------------- 8-bit instance ----------------
   logic       s_start, s_bin;
   logic [7:0] s_a, s_b;
   logic       s_ready, s_done, s_bout, s_ovf, s_zero;
   logic [7:0] s_diff;

   serial_sub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(s_start), .a(s_a), .b(s_b), .bin(s_bin),
      .ready(s_ready), .done(s_done), .diff(s_diff), .bout(s_bout), .ovf(s_ovf), .zero(s_zero)
   );

   // ---------------- 16-bit instances ----------------
   logic        w_start, w_bin;
   logic [15:0] w_a, w_b;
   logic [3:0]  wready, wdone, wbout, wovf, wzero;
   logic [15:0] wdiff [4];

   for (genvar g = 0; g < 4; g++) begin : g_wide
      serial_sub #(.WIDTH(16), .DIGIT((g == 3) ? 16 : (1 << g))) u_dut (
         .clk(clk), .rst_n(rst_n), .start(w_start), .a(w_a), .b(w_b), .bin(w_bin),
         .ready(wready[g]), .done(wdone[g]), .diff(wdiff[g]), .bout(wbout[g]),
         .ovf(wovf[g]), .zero(wzero[g])
      );
   end

   function automatic int nw(input int i);
      return 16 / ((i == 3) ? 16 : (1 << i));
   endfunction

   // Whole-word reference: one wide subtraction, borrow taken from bit 16.
   function automatic exp_t ref_sub16(input logic [15:0] a, input logic [15:0] b, input logic bin);
      exp_t        e;
      logic [16:0] t;
      t      = {1'b0, a} - {1'b0, b} - {16'd0, bin};
      e.diff = t[15:0];
      e.bout = t[16];
      e.ovf  = (a[15] ^ b[15]) & (a[15] ^ e.diff[15]);
      e.zero = (e.diff == 16'd0);
      e.c0   = 0;
      return e;
   endfunction

   exp_t       q8[$];
   exp_t       wq[$];
   exp_t       m8_e;
   logic [3:0] wseen = 4'h0;

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (rst_n && s_done) begin
         if (q8.size() == 0) begin
            check_val("done8_unexpected", {31'd0, s_done}, 32'd0);
         end else begin
            m8_e = q8.pop_front();
            check_val("diff8", {24'd0, s_diff}, {16'd0, m8_e.diff});
            check_val("bout8", {31'd0, s_bout}, {31'd0, m8_e.bout});
            check_val("ovf8",  {31'd0, s_ovf},  {31'd0, m8_e.ovf});
            check_val("zero8", {31'd0, s_zero}, {31'd0, m8_e.zero});
            check_val("lat8",  cyc - m8_e.c0, 32'd8);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) begin
            if (wdone[i]) begin
               if (wq.size() == 0 || wseen[i]) begin
                  check_val($sformatf("doneW%0d_unexpected", i), {31'd0, wdone[i]}, 32'd0);
               end else begin
                  check_val($sformatf("diffW%0d", i), {16'd0, wdiff[i]}, {16'd0, wq[0].diff});
                  check_val($sformatf("boutW%0d", i), {31'd0, wbout[i]}, {31'd0, wq[0].bout});
                  check_val($sformatf("ovfW%0d", i),  {31'd0, wovf[i]},  {31'd0, wq[0].ovf});
                  check_val($sformatf("zeroW%0d", i), {31'd0, wzero[i]}, {31'd0, wq[0].zero});
                  check_val($sformatf("latW%0d", i),  cyc - wq[0].c0, nw(i));
                  wseen[i] = 1'b1;
               end
            end
         end
         if (wseen == 4'hF) begin
            void'(wq.pop_front());
            wseen = 4'h0;
         end
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic wait_ready8();
      for (int k = 0; k < 40 && !s_ready; k++) @(negedge clk);
      check_val("ready8_wait", {31'd0, s_ready}, 32'd1);
   endtask

   task automatic drain8();
      for (int k = 0; k < 40 && q8.size() != 0; k++) @(negedge clk);
      check_val("drain8", q8.size(), 32'd0);
      q8.delete();
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input logic [7:0] ed, input logic eb, input logic eo, input logic ez);
      exp_t e;
      wait_ready8();
      s_a = a; s_b = b; s_bin = bin; s_start = 1'b1;
      e.diff = {8'd0, ed}; e.bout = eb; e.ovf = eo; e.zero = ez;
      e.c0 = cyc + 1;
      q8.push_back(e);
      @(negedge clk);
      s_start = 1'b0;
      s_a = 8'($urandom); s_b = 8'($urandom); s_bin = 1'($urandom);
   endtask

   task automatic opw(input logic [15:0] a, input logic [15:0] b, input logic bin, input exp_t e);
      for (int k = 0; k < 40 && wready != 4'hF; k++) @(negedge clk);
      check_val("readyW_wait", {28'd0, wready}, 32'hF);
      w_a = a; w_b = b; w_bin = bin; w_start = 1'b1;
      e.c0 = cyc + 1;
      wseen = 4'h0;
      wq.push_back(e);
      @(negedge clk);
      w_start = 1'b0;
      w_a = 16'($urandom); w_b = 16'($urandom); w_bin = 1'($urandom);
      for (int k = 0; k < 40 && wq.size() != 0; k++) @(negedge clk);
      check_val("drainW", wq.size(), 32'd0);
      if (wq.size() != 0) begin
         wq.delete();
         wseen = 4'h0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      exp_t we;
      int   c0;
      logic [15:0] ra, rb;
      logic        rbin;

      rst_n = 1'b0;
      s_start = 1'b0; s_a = '0; s_b = '0; s_bin = 1'b0;
      w_start = 1'b0; w_a = '0; w_b = '0; w_bin = 1'b0;

      // Reset held with random inputs.
      repeat (4) begin
         @(negedge clk);
         s_a = 8'($urandom); s_b = 8'($urandom); s_bin = 1'($urandom); s_start = 1'($urandom);
         w_a = 16'($urandom); w_b = 16'($urandom); w_bin = 1'($urandom); w_start = 1'($urandom);
      end
      @(negedge clk);
      check_val("rst_ready", {31'd0, s_ready}, 32'd1);
      check_val("rst_done",  {31'd0, s_done},  32'd0);
      check_val("rst_diff",  {24'd0, s_diff},  32'd0);
      check_val("rst_bout",  {31'd0, s_bout},  32'd0);
      check_val("rst_ovf",   {31'd0, s_ovf},   32'd0);
      check_val("rst_zero",  {31'd0, s_zero},  32'd0);
      check_val("rst_readyW", {28'd0, wready}, 32'hF);
      check_val("rst_doneW",  {28'd0, wdone},  32'h0);
      s_start = 1'b0; w_start = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_val("post_rst_ready", {31'd0, s_ready}, 32'd1);
      check_val("post_rst_done",  {31'd0, s_done},  32'd0);

      // Basic ops and flags.
      op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
      drain8();
      op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
      op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
      op8(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
      drain8();

      // Busy handling: start pulses during RUN and DONE must be ignored.
      wait_ready8();
      s_a = 8'h10; s_b = 8'h01; s_bin = 1'b0; s_start = 1'b1;
      c0 = cyc + 1;
      we.diff = 16'h000F; we.bout = 1'b0; we.ovf = 1'b0; we.zero = 1'b0; we.c0 = c0;
      q8.push_back(we);
      @(negedge clk);
      s_start = 1'b0;
      repeat (3) @(negedge clk);
      s_a = 8'hFF; s_b = 8'hFF; s_start = 1'b1;
      check_val("busy_ready_in_run", {31'd0, s_ready}, 32'd0);
      @(negedge clk);
      s_start = 1'b0;
      for (int k = 0; k < 40 && !s_done; k++) @(negedge clk);
      check_val("busy_done_seen", {31'd0, s_done}, 32'd1);
      s_a = 8'hFF; s_b = 8'hFF; s_start = 1'b1;
      check_val("busy_ready_in_done", {31'd0, s_ready}, 32'd0);
      @(negedge clk);
      // IDLE again after E(N+1); the next acceptance can happen at E(N+2).
      check_val("busy_ready_back", {31'd0, s_ready}, 32'd1);
      check_val("busy_ready_lat", cyc - c0, 32'd9);
      s_start = 1'b0;
      repeat (12) @(negedge clk);
      check_val("busy_single_done", q8.size(), 32'd0);

      // Reset mid-op: abort 3 edges into RUN, no done for that op.
      op8(8'h77, 8'h11, 1'b0, 8'h66, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_val("abort_ready", {31'd0, s_ready}, 32'd1);
      check_val("abort_done",  {31'd0, s_done},  32'd0);
      check_val("abort_diff",  {24'd0, s_diff},  32'd0);
      q8.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check_val("abort_no_done", {31'd0, s_done}, 32'd0);
      op8(8'h20, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
      drain8();

      // Wide, multi-bit digits.
      we.diff = 16'h0FFE; we.bout = 1'b0; we.ovf = 1'b0; we.zero = 1'b0; we.c0 = 0;
      opw(16'h1234, 16'h0235, 1'b1, we);
      we.diff = 16'h0000; we.bout = 1'b0; we.ovf = 1'b0; we.zero = 1'b1;
      opw(16'h8000, 16'h8000, 1'b0, we);
      we.diff = 16'h7FFF; we.bout = 1'b0; we.ovf = 1'b1; we.zero = 1'b0;
      opw(16'h8000, 16'h0000, 1'b1, we);
      for (int i = 0; i < 1000; i++) begin
         ra   = 16'($urandom);
         rb   = 16'($urandom);
         rbin = 1'($urandom);
         if (i % 50 == 0) begin
            rb   = ra;
            rbin = 1'b0;
         end
         opw(ra, rb, rbin, ref_sub16(ra, rb, rbin));
      end

      check_val("q8_empty", q8.size(), 32'd0);
      check_val("wq_empty", wq.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
